// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive path.
package usb_rx_pkg;

  typedef enum logic [3:0] {
    IDLE,
    RCV_SYNC,
    RCV_BYTE,
    STORE,
    EOP_WAIT,
    ERR_WAIT,
    ERR_IDLE
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;

  // PID nibbles as received (LSB-first), for the downstream PID checker
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

endpackage

// File: rtl/usb_rx_ctrl_bit_counter.sv
// 3-bit accepted-bit counter; byte_rdy is registered so it lines up with a
// complete byte on rcv_data.
module rx_bit_counter (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_clear,
  input  logic       i_en,
  output logic [2:0] o_cnt,
  output logic       o_byte_rdy
);

  logic [2:0] r_cnt;
  logic       r_byte_rdy;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt      <= 3'd0;
      r_byte_rdy <= 1'b0;
    end else if (i_clear) begin
      r_cnt      <= 3'd0;
      r_byte_rdy <= 1'b0;
    end else begin
      r_byte_rdy <= i_en && (r_cnt == 3'd7);
      if (i_en) r_cnt <= r_cnt + 3'd1;
    end
  end

  assign o_cnt      = r_cnt;
  assign o_byte_rdy = r_byte_rdy;

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB full-speed receive controller: SYNC check, byte framing, FIFO writes,
// EOP alignment and sticky error handling.
module usb_rx_ctrl
  import usb_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         MAX_BYTES = 64,
  parameter int         CNT_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             d_edge,
  input  logic             eop,
  input  logic             shift_enable,
  input  logic             shift_stop,
  input  logic [7:0]       rcv_data,
  output logic             rcving,
  output logic             w_enable,
  output logic             r_error,
  output logic             pkt_done,
  output logic [CNT_W-1:0] byte_count
);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_byte_cnt;
  logic             r_idle_ok;
  logic [2:0]       w_bit_cnt;
  logic             w_byte_rdy, w_accept, w_eop_smp, w_aligned_eop;
  logic             w_clear, w_start, w_store_ok;

  assign w_accept      = shift_enable & ~shift_stop & ~eop;
  assign w_eop_smp     = eop & shift_enable;
  assign w_aligned_eop = w_eop_smp && (w_bit_cnt == 3'd0) && !w_byte_rdy;
  assign w_clear       = (r_state == IDLE) || (r_state == ERR_IDLE);
  assign w_start       = d_edge && ((r_state == IDLE) ||
                                    ((r_state == ERR_IDLE) && r_idle_ok));
  assign w_store_ok    = r_byte_cnt < CNT_W'(MAX_BYTES);

  rx_bit_counter u_bit_cnt (
    .clk       (clk),
    .n_rst     (n_rst),
    .i_clear   (w_clear),
    .i_en      (w_accept),
    .o_cnt     (w_bit_cnt),
    .o_byte_rdy(w_byte_rdy)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    rcving   = 1'b0;
    w_enable = 1'b0;
    pkt_done = 1'b0;
    r_error  = 1'b0;
    case (r_state)
      IDLE: if (w_start) w_next = RCV_SYNC;
      RCV_SYNC: begin
        rcving = 1'b1;
        if (w_byte_rdy)     w_next = (rcv_data == SYNC_BYTE) ? RCV_BYTE : ERR_WAIT;
        else if (w_eop_smp) w_next = ERR_WAIT;
      end
      RCV_BYTE: begin
        rcving = 1'b1;
        // a completed byte is stored before any EOP is looked at
        if (w_byte_rdy) w_next = STORE;
        else if (w_aligned_eop) begin
          w_next   = EOP_WAIT;
          pkt_done = 1'b1;
        end else if (w_eop_smp) w_next = ERR_WAIT;
      end
      STORE: begin
        rcving = 1'b1;
        if (w_store_ok) begin
          w_enable = 1'b1;
          if (w_aligned_eop) begin
            w_next   = EOP_WAIT;
            pkt_done = 1'b1;
          end else w_next = RCV_BYTE;
        end else w_next = ERR_WAIT;
      end
      EOP_WAIT: begin
        rcving = 1'b1;
        if (d_edge) w_next = IDLE;
      end
      ERR_WAIT: begin
        rcving  = 1'b1;
        r_error = 1'b1;
        if (w_eop_smp) w_next = ERR_IDLE;
      end
      ERR_IDLE: begin
        r_error = 1'b1;
        if (w_start) w_next = RCV_SYNC;
      end
      default: w_next = IDLE;
    endcase
  end

  // Armed only after a quiet non-SE0 cycle, so the SE0->J edge cannot restart
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                    r_idle_ok <= 1'b0;
    else if (r_state != ERR_IDLE)  r_idle_ok <= 1'b0;
    else if (!eop && !d_edge)      r_idle_ok <= 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                              r_byte_cnt <= '0;
    else if (w_start)                        r_byte_cnt <= '0;
    else if (r_state == STORE && w_store_ok) r_byte_cnt <= r_byte_cnt + CNT_W'(1);
  end

  assign byte_count = r_byte_cnt;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Directed bench for usb_rx_ctrl (MAX_BYTES=4 so overflow is reachable).
module tb_usb_rx_ctrl;
  localparam int MAXB = 4;
  localparam int CW   = $clog2(MAXB + 1);

  logic clk = 1'b0;
  logic n_rst, d_edge, eop, shift_enable, shift_stop;
  logic [7:0] rcv_data, rsr;
  logic rcving, w_enable, r_error, pkt_done;
  logic [CW-1:0] byte_count;
  logic [7:0] wr_q[$];
  int pkt_cnt = 0;
  int checks = 0, failures = 0;
  int wb, pb;

  usb_rx_ctrl #(.MAX_BYTES(MAXB)) dut (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .eop(eop),
    .shift_enable(shift_enable), .shift_stop(shift_stop), .rcv_data(rcv_data),
    .rcving(rcving), .w_enable(w_enable), .r_error(r_error),
    .pkt_done(pkt_done), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (w_enable) wr_q.push_back(rcv_data);
    if (pkt_done) pkt_cnt++;
  end

  task automatic cyc; @(posedge clk); #1; endtask

  task automatic do_reset;
    n_rst = 1'b0; d_edge = 0; eop = 0; shift_enable = 0; shift_stop = 0;
    rcv_data = 8'h00; rsr = 8'h00;
    cyc(); cyc(); n_rst = 1'b1; cyc();
    wb = wr_q.size(); pb = pkt_cnt;
  endtask

  task automatic send_bit(input logic b, input logic stop);
    shift_enable = 1'b1; shift_stop = stop;
    if (!stop) rsr = {b, rsr[7:1]};
    rcv_data = rsr;
    cyc();
    shift_enable = 1'b0; shift_stop = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0);
  endtask

  task automatic start_pkt; d_edge = 1'b1; cyc(); d_edge = 1'b0; cyc(); endtask

  task automatic send_eop;
    eop = 1'b1;
    repeat (2) begin shift_enable = 1'b1; cyc(); shift_enable = 1'b0; repeat (3) cyc(); end
  endtask

  task automatic line_j; eop = 1'b0; d_edge = 1'b1; cyc(); d_edge = 1'b0; repeat (3) cyc(); endtask

  task automatic test_reset;
    n_rst = 1'b0; d_edge = 0; eop = 0; shift_enable = 0; shift_stop = 0; rcv_data = 0; rsr = 0;
    cyc();
    checks++; if (rcving !== 1'b0) begin failures++; $display("FAIL reset_rcving: got %b expected 0", rcving); end
    checks++; if (w_enable !== 1'b0) begin failures++; $display("FAIL reset_w_enable: got %b expected 0", w_enable); end
    checks++; if (r_error !== 1'b0) begin failures++; $display("FAIL reset_r_error: got %b expected 0", r_error); end
    checks++; if (pkt_done !== 1'b0) begin failures++; $display("FAIL reset_pkt_done: got %b expected 0", pkt_done); end
    checks++; if (byte_count !== CW'(0)) begin failures++; $display("FAIL reset_byte_count: got %0d expected 0", byte_count); end
  endtask

  task automatic test_good_packet;
    logic [7:0] v;
    do_reset(); start_pkt(); send_byte(8'h80);
    v = 8'hC3;
    for (int i = 0; i < 7; i++) send_bit(v[i], 1'b0);
    shift_enable = 1'b1; rsr = {v[7], rsr[7:1]}; rcv_data = rsr; cyc(); shift_enable = 1'b0;
    checks++; if (w_enable !== 1'b0) begin failures++; $display("FAIL good_wen_lat1: got %b expected 0", w_enable); end
    cyc();
    checks++; if (w_enable !== 1'b1) begin failures++; $display("FAIL good_wen_lat2: got %b expected 1", w_enable); end
    repeat (2) cyc();
    send_byte(8'hA5);
    checks++; if (byte_count !== CW'(2)) begin failures++; $display("FAIL good_byte_count: got %0d expected 2", byte_count); end
    send_eop();
    checks++; if (pkt_cnt - pb !== 1) begin failures++; $display("FAIL good_pkt_done: got %0d expected 1", pkt_cnt - pb); end
    checks++; if (wr_q.size() - wb !== 2) begin failures++; $display("FAIL good_writes: got %0d expected 2", wr_q.size() - wb); end
    if (wr_q.size() - wb == 2) begin
      checks++; if (wr_q[wb] !== 8'hC3) begin failures++; $display("FAIL good_data0: got %h expected c3", wr_q[wb]); end
      checks++; if (wr_q[wb+1] !== 8'hA5) begin failures++; $display("FAIL good_data1: got %h expected a5", wr_q[wb+1]); end
    end
    checks++; if (rcving !== 1'b1 || r_error !== 1'b0) begin failures++; $display("FAIL good_eop_wait: got rcving=%b r_error=%b expected 1/0", rcving, r_error); end
    line_j();
    checks++; if (rcving !== 1'b0) begin failures++; $display("FAIL good_rcving_after_j: got %b expected 0", rcving); end
  endtask

  task automatic test_bad_sync;
    do_reset(); start_pkt(); send_byte(8'h81);
    checks++; if (r_error !== 1'b1 || rcving !== 1'b1) begin failures++; $display("FAIL badsync_err_wait: got r_error=%b rcving=%b expected 1/1", r_error, rcving); end
    send_byte(8'h55);
    checks++; if (wr_q.size() - wb !== 0) begin failures++; $display("FAIL badsync_writes: got %0d expected 0", wr_q.size() - wb); end
    send_eop();
    checks++; if (rcving !== 1'b0 || r_error !== 1'b1) begin failures++; $display("FAIL badsync_err_idle: got rcving=%b r_error=%b expected 0/1", rcving, r_error); end
    line_j();
    checks++; if (r_error !== 1'b1) begin failures++; $display("FAIL badsync_j_edge_holds: got %b expected 1", r_error); end
    start_pkt();
    checks++; if (r_error !== 1'b0 || rcving !== 1'b1) begin failures++; $display("FAIL badsync_restart: got r_error=%b rcving=%b expected 0/1", r_error, rcving); end
    send_byte(8'h80); send_byte(8'h3C); send_eop(); line_j();
    checks++; if (wr_q.size() - wb !== 1 || pkt_cnt - pb !== 1) begin failures++; $display("FAIL badsync_recover: got writes=%0d pkts=%0d expected 1/1", wr_q.size() - wb, pkt_cnt - pb); end
    else begin
      checks++; if (wr_q[wb] !== 8'h3C) begin failures++; $display("FAIL badsync_recover_data: got %h expected 3c", wr_q[wb]); end
    end
  endtask

  task automatic test_misaligned;
    do_reset(); start_pkt(); send_byte(8'h80);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    eop = 1'b1; shift_enable = 1'b1; cyc(); shift_enable = 1'b0;
    checks++; if (r_error !== 1'b1 || rcving !== 1'b1) begin failures++; $display("FAIL misalign_err_wait: got r_error=%b rcving=%b expected 1/1", r_error, rcving); end
    repeat (3) cyc();
    shift_enable = 1'b1; cyc(); shift_enable = 1'b0;
    checks++; if (r_error !== 1'b1 || rcving !== 1'b0) begin failures++; $display("FAIL misalign_err_idle: got r_error=%b rcving=%b expected 1/0", r_error, rcving); end
    checks++; if (pkt_cnt - pb !== 0) begin failures++; $display("FAIL misalign_pkt_done: got %0d expected 0", pkt_cnt - pb); end
    line_j();
  endtask

  task automatic test_stuffing;
    do_reset(); start_pkt(); send_byte(8'h80);
    repeat (6) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    repeat (2) send_bit(1'b1, 1'b0);
    send_eop();
    checks++; if (wr_q.size() - wb !== 1) begin failures++; $display("FAIL stuff_writes: got %0d expected 1", wr_q.size() - wb); end
    else begin
      checks++; if (wr_q[wb] !== 8'hFF) begin failures++; $display("FAIL stuff_data: got %h expected ff", wr_q[wb]); end
    end
    checks++; if (byte_count !== CW'(1)) begin failures++; $display("FAIL stuff_byte_count: got %0d expected 1", byte_count); end
    checks++; if (pkt_cnt - pb !== 1 || r_error !== 1'b0) begin failures++; $display("FAIL stuff_aligned_end: got pkts=%0d r_error=%b expected 1/0", pkt_cnt - pb, r_error); end
    line_j();
  endtask

  task automatic test_overflow;
    do_reset(); start_pkt(); send_byte(8'h80);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    checks++; if (byte_count !== CW'(4) || r_error !== 1'b0) begin failures++; $display("FAIL ovf_full: got count=%0d r_error=%b expected 4/0", byte_count, r_error); end
    send_byte(8'h55);
    checks++; if (r_error !== 1'b1) begin failures++; $display("FAIL ovf_r_error: got %b expected 1", r_error); end
    checks++; if (wr_q.size() - wb !== 4) begin failures++; $display("FAIL ovf_writes: got %0d expected 4", wr_q.size() - wb); end
    else begin
      checks++; if (wr_q[wb+3] !== 8'h44) begin failures++; $display("FAIL ovf_last_data: got %h expected 44", wr_q[wb+3]); end
    end
    send_eop(); line_j();
    checks++; if (byte_count !== CW'(4)) begin failures++; $display("FAIL ovf_count_held: got %0d expected 4", byte_count); end
  endtask

  task automatic test_reset_mid;
    do_reset(); start_pkt(); send_byte(8'h80);
    send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    #2 n_rst = 1'b0; #1;
    checks++; if (rcving !== 1'b0 || r_error !== 1'b0 || w_enable !== 1'b0) begin failures++; $display("FAIL midreset_outputs: got rcving=%b r_error=%b w_enable=%b expected 0/0/0", rcving, r_error, w_enable); end
    checks++; if (byte_count !== CW'(0)) begin failures++; $display("FAIL midreset_byte_count: got %0d expected 0", byte_count); end
    cyc(); n_rst = 1'b1; cyc();
    start_pkt(); send_byte(8'h80); send_byte(8'h5A); send_eop();
    checks++; if (wr_q.size() - wb !== 1 || pkt_cnt - pb !== 1 || r_error !== 1'b0) begin failures++; $display("FAIL midreset_recover: got writes=%0d pkts=%0d r_error=%b expected 1/1/0", wr_q.size() - wb, pkt_cnt - pb, r_error); end
    else begin
      checks++; if (wr_q[wb] !== 8'h5A) begin failures++; $display("FAIL midreset_data: got %h expected 5a", wr_q[wb]); end
    end
    line_j();
    checks++; if (rcving !== 1'b0) begin failures++; $display("FAIL midreset_idle: got %b expected 0", rcving); end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_sync();
    test_misaligned();
    test_stuffing();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
